// File: rtl/branch_spec_ctrl_if.sv
// Decode/commit/predictor bundle for branch_spec_ctrl.
// BRANCH_STATS_EN adds the stat_branches/stat_mispredicts counters.
interface branch_spec_ctrl_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          dec_valid;
  logic [11:0]   dec_opcode;
  logic [31:0]   dec_pc;
  logic [31:0]   dec_target;
  logic          pred_taken;
  logic          cmt_valid;
  logic [11:0]   cmt_opcode;
  logic          cmt_taken;
  logic          dec_stall;
  logic          wrong_prediction;
  logic [11:0]   bpu_commit_opcode;
  logic          flush;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] inflight_count;
`ifdef BRANCH_STATS_EN
  logic [31:0]   stat_branches;
  logic [31:0]   stat_mispredicts;
`endif

  modport master (
    output dec_valid, dec_opcode, dec_pc, dec_target,
    output pred_taken, cmt_valid, cmt_opcode, cmt_taken,
    input  dec_stall, wrong_prediction, bpu_commit_opcode,
    input  flush, redirect_pc, inflight_count
`ifdef BRANCH_STATS_EN
    , input stat_branches, stat_mispredicts
`endif
  );

  modport slave (
    input  dec_valid, dec_opcode, dec_pc, dec_target,
    input  pred_taken, cmt_valid, cmt_opcode, cmt_taken,
    output dec_stall, wrong_prediction, bpu_commit_opcode,
    output flush, redirect_pc, inflight_count
`ifdef BRANCH_STATS_EN
    , output stat_branches, stat_mispredicts
`endif
  );
endinterface

// File: rtl/branch_spec_ctrl.sv
// In-flight branch queue with mispredict flush/redirect and decode recovery.
// Optional BRANCH_STATS_EN adds pop and mispredict-pop counters.
module branch_spec_ctrl #(
  parameter int DEPTH          = 4,
  parameter int RECOVER_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  branch_spec_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(RECOVER_CYCLES + 1);
  localparam logic [AW:0]   FULL   = (AW+1)'(DEPTH);
  localparam logic [RW-1:0] RC_TOP = RW'(RECOVER_CYCLES - 1);
  localparam logic [11:0]   OP_BEQ = 12'h063;
  localparam logic [11:0]   OP_BNE = 12'h0e3;

  typedef enum logic [0:0] {RUN, RECOVER} state_t;

  state_t        state_q;
  logic [RW-1:0] rcnt_q;
  logic [AW-1:0] head_q, tail_q;
  logic [AW:0]   cnt_q;
  logic          wp_q, flush_q;
  logic [11:0]   bpu_q;
  logic [31:0]   redir_q;

  logic [31:0]   pc_q  [DEPTH];
  logic [31:0]   tgt_q [DEPTH];
  logic          pred_q[DEPTH];

  logic        full, recov, pop, mis, push;
  logic [31:0] redir_d;

  function automatic logic is_br(input logic [11:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  always_comb begin
    full  = (cnt_q == FULL);
    recov = (state_q == RECOVER);
    pop   = bus.cmt_valid & is_br(bus.cmt_opcode)
          & ~recov & (cnt_q != '0);
    mis   = pop & (pred_q[head_q] != bus.cmt_taken);
    // A full queue still accepts a push when a correct pop frees the head.
    push  = bus.dec_valid & is_br(bus.dec_opcode)
          & ~recov & (~full | pop) & ~mis;
    redir_d = bus.cmt_taken ? tgt_q[head_q]
                            : pc_q[head_q] + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[tail_q]   <= bus.dec_pc;
      tgt_q[tail_q]  <= bus.dec_target;
      pred_q[tail_q] <= bus.pred_taken;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      rcnt_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      wp_q    <= 1'b0;
      flush_q <= 1'b0;
      bpu_q   <= '0;
      redir_q <= '0;
    end else begin
      wp_q    <= mis;
      flush_q <= mis;
      bpu_q   <= pop ? bus.cmt_opcode : 12'h000;
      if (mis) redir_q <= redir_d;
      unique case (state_q)
        RUN: begin
          if (mis) begin
            state_q <= RECOVER;
            rcnt_q  <= RC_TOP;
          end
        end
        RECOVER: begin
          if (rcnt_q == '0) state_q <= RUN;
          else rcnt_q <= rcnt_q - RW'(1);
        end
        default: state_q <= RUN;
      endcase
      // Everything younger than a mispredicted branch is wrong-path.
      if (mis) begin
        head_q <= '0;
        tail_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push) tail_q <= tail_q + AW'(1);
        if (pop)  head_q <= head_q + AW'(1);
        if (push && !pop) cnt_q <= cnt_q + (AW+1)'(1);
        if (pop && !push) cnt_q <= cnt_q - (AW+1)'(1);
      end
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] st_br_q, st_mis_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_br_q  <= '0;
      st_mis_q <= '0;
    end else begin
      if (pop) st_br_q  <= st_br_q + 32'd1;
      if (mis) st_mis_q <= st_mis_q + 32'd1;
    end
  end

  assign bus.stat_branches    = st_br_q;
  assign bus.stat_mispredicts = st_mis_q;
`endif

  assign bus.dec_stall         = full | recov;
  assign bus.wrong_prediction  = wp_q;
  assign bus.flush             = flush_q;
  assign bus.bpu_commit_opcode = bpu_q;
  assign bus.redirect_pc       = redir_q;
  assign bus.inflight_count    = cnt_q;
endmodule

// File: tb/tb_branch_spec_ctrl.sv
// Directed bench for branch_spec_ctrl (DEPTH=4, RECOVER_CYCLES=2).
// Stat checks are compiled in when BRANCH_STATS_EN is defined.
module tb_branch_spec_ctrl;
  localparam logic [11:0] BEQ = 12'h063;
  localparam logic [11:0] BNE = 12'h0e3;
  localparam logic [11:0] ADD = 12'h033;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  branch_spec_ctrl_if #(.DEPTH(4)) bus ();

  branch_spec_ctrl #(
    .DEPTH(4),
    .RECOVER_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic v, input logic [11:0] op,
                     input logic [31:0] pc, input logic [31:0] tg,
                     input logic pr);
    bus.dec_valid  = v;
    bus.dec_opcode = op;
    bus.dec_pc     = pc;
    bus.dec_target = tg;
    bus.pred_taken = pr;
  endtask

  task automatic cmt(input logic v, input logic [11:0] op,
                     input logic tk);
    bus.cmt_valid  = v;
    bus.cmt_opcode = op;
    bus.cmt_taken  = tk;
  endtask

  task automatic idle;
    dec(1'b0, 12'h0, 32'h0, 32'h0, 1'b0);
    cmt(1'b0, 12'h0, 1'b0);
  endtask

  initial begin
    idle();
    #1;
    chk("rst_cnt",   32'(bus.inflight_count), 32'd0);
    chk("rst_stall", 32'(bus.dec_stall), 32'd0);
    chk("rst_flush", 32'(bus.flush), 32'd0);
    chk("rst_wp",    32'(bus.wrong_prediction), 32'd0);
    chk("rst_bpu",   32'(bus.bpu_commit_opcode), 32'd0);
    chk("rst_redir", bus.redirect_pc, 32'd0);
    step();
    step();
    rst = 1'b0;

    // mispredict: head {0x10,0x40,pred0}, bne taken
    dec(1'b1, BEQ, 32'h10, 32'h40, 1'b0);
    step();
    chk("p1_cnt", 32'(bus.inflight_count), 32'd1);
    idle();
    cmt(1'b1, BNE, 1'b1);
    step();
    chk("m1_wp",    32'(bus.wrong_prediction), 32'd1);
    chk("m1_flush", 32'(bus.flush), 32'd1);
    chk("m1_redir", bus.redirect_pc, 32'h40);
    chk("m1_cnt",   32'(bus.inflight_count), 32'd0);
    chk("m1_stall", 32'(bus.dec_stall), 32'd1);
    chk("m1_bpu",   32'(bus.bpu_commit_opcode), 32'(BNE));
    idle();
    step();
    chk("m1_stall2", 32'(bus.dec_stall), 32'd1);
    chk("m1_flush2", 32'(bus.flush), 32'd0);
    chk("m1_bpu2",   32'(bus.bpu_commit_opcode), 32'd0);
    step();
    chk("m1_stall3", 32'(bus.dec_stall), 32'd0);

    // fill to DEPTH
    for (int i = 0; i < 4; i++) begin
      dec(1'b1, BEQ, 32'h100 + 32'(i), 32'h200 + 32'(i), 1'b0);
      step();
    end
    chk("fill_cnt",   32'(bus.inflight_count), 32'd4);
    chk("fill_stall", 32'(bus.dec_stall), 32'd1);
    dec(1'b1, BEQ, 32'h999, 32'h999, 1'b1);
    step();
    chk("drop5_cnt", 32'(bus.inflight_count), 32'd4);

    // full: push + correct pop
    dec(1'b1, BEQ, 32'h104, 32'h204, 1'b0);
    cmt(1'b1, BEQ, 1'b0);
    step();
    chk("pp_cnt",   32'(bus.inflight_count), 32'd4);
    chk("pp_wp",    32'(bus.wrong_prediction), 32'd0);
    chk("pp_flush", 32'(bus.flush), 32'd0);
    chk("pp_bpu",   32'(bus.bpu_commit_opcode), 32'(BEQ));
    idle();
    step();
    chk("pp_bpu2", 32'(bus.bpu_commit_opcode), 32'd0);

    // head 0x101 pred0 resolved taken; concurrent push dropped
    dec(1'b1, BEQ, 32'h999, 32'h999, 1'b0);
    cmt(1'b1, BNE, 1'b1);
    step();
    chk("m2_redir", bus.redirect_pc, 32'h201);
    chk("m2_cnt",   32'(bus.inflight_count), 32'd0);
    chk("m2_flush", 32'(bus.flush), 32'd1);
    idle();
    cmt(1'b1, BEQ, 1'b1);
    step();
    chk("rc_wp",  32'(bus.wrong_prediction), 32'd0);
    chk("rc_bpu", 32'(bus.bpu_commit_opcode), 32'd0);
    idle();
    step();

    // head {0x20, pred1}, not taken -> 0x21
    dec(1'b1, BEQ, 32'h20, 32'h30, 1'b1);
    step();
    dec(1'b1, BEQ, 32'h50, 32'h60, 1'b0);
    cmt(1'b1, BEQ, 1'b0);
    step();
    chk("m3_redir", bus.redirect_pc, 32'h21);
    chk("m3_cnt",   32'(bus.inflight_count), 32'd0);
    idle();
    step();
    step();
    chk("m3_stall", 32'(bus.dec_stall), 32'd0);

    // pop on empty queue ignored
    cmt(1'b1, BEQ, 1'b1);
    step();
    chk("e_wp",    32'(bus.wrong_prediction), 32'd0);
    chk("e_flush", 32'(bus.flush), 32'd0);
    chk("e_bpu",   32'(bus.bpu_commit_opcode), 32'd0);
    chk("e_redir", bus.redirect_pc, 32'h21);
    chk("e_stall", 32'(bus.dec_stall), 32'd0);

    // pc+1 wraps
    idle();
    dec(1'b1, BNE, 32'hffff_ffff, 32'h5, 1'b1);
    step();
    idle();
    cmt(1'b1, BNE, 1'b0);
    step();
    chk("wrap_redir", bus.redirect_pc, 32'h0);
    idle();
    step();
    step();

    // non-branch commit ignored
    dec(1'b1, BEQ, 32'h60, 32'h70, 1'b0);
    step();
    idle();
    cmt(1'b1, ADD, 1'b1);
    step();
    chk("add_cnt", 32'(bus.inflight_count), 32'd1);
    chk("add_bpu", 32'(bus.bpu_commit_opcode), 32'd0);
    chk("add_fl",  32'(bus.flush), 32'd0);

    // reset mid-RECOVER
    cmt(1'b1, BEQ, 1'b1);
    step();
    idle();
    chk("r_flush", 32'(bus.flush), 32'd1);
`ifdef BRANCH_STATS_EN
    chk("st_br",  bus.stat_branches, 32'd6);
    chk("st_mis", bus.stat_mispredicts, 32'd5);
`endif
    rst = 1'b1;
    #1;
    chk("r_stall", 32'(bus.dec_stall), 32'd0);
    chk("r_flush0", 32'(bus.flush), 32'd0);
    chk("r_wp",    32'(bus.wrong_prediction), 32'd0);
    chk("r_redir", bus.redirect_pc, 32'd0);
    chk("r_cnt",   32'(bus.inflight_count), 32'd0);
`ifdef BRANCH_STATS_EN
    chk("r_stbr",  bus.stat_branches, 32'd0);
    chk("r_stmis", bus.stat_mispredicts, 32'd0);
`endif
    #1;
    rst = 1'b0;
    dec(1'b1, BEQ, 32'h80, 32'h90, 1'b0);
    step();
    chk("r_push", 32'(bus.inflight_count), 32'd1);
    chk("r_st2",  32'(bus.dec_stall), 32'd0);
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
